bypass_sched: RTL and testbench
===============================

BYPASS_SCHED -- requirements
Module: bypass_sched

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-002 The block SHALL have parameter AW, default 5, meaning the register-address width.
REQ-003 The block SHALL have parameter NSTG, default 3, meaning the number of tracked stages (0=E, 1=M, 2=W).
REQ-004 The block SHALL have parameter NRD, default 2, meaning the number of D-stage read ports.
REQ-005 The block SHALL have parameter TW, default 2, meaning the width of the Tnew and Tuse fields.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 iss_valid  in  1  D-stage instruction advances to E this cycle unless stalled.
REQ-009 iss_we  in  1  issuing instruction writes the register file.
REQ-010 iss_wa  in  AW  destination register of the issuing instruction.
REQ-011 iss_tnew  in  TW  cycles after entering E until the result exists (ALU=1, load=2, jal=0).
REQ-012 flush  in  1  kill the issuing instruction; E receives a bubble.
REQ-013 stg_data  in  NSTG*DW  result data held in the pipeline register of each stage; slice i belongs to stage i.
REQ-014 rd_addr  in  NRD*AW  read addresses, one per port.
REQ-015 rd_tuse  in  NRD*TW  cycles until each port's operand is consumed.
REQ-016 rf_data  in  NRD*DW  register-file read data, one per port.
REQ-017 fwd_data  out  NRD*DW  bypassed operand, one per port.
REQ-018 fwd_pend  out  NRD  per port: the youngest producer has not yet produced its result.
REQ-019 stall  out  1  freeze PC and D; insert a bubble into E.
REQ-020 stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-021 The block SHALL hold an NSTG-entry table; each entry holds {v, wa, tnew}, and entry i describes the instruction in stage i.
REQ-022 At each edge, entry i (i≥1) SHALL take entry i-1, with tnew decremented and saturating at 0, whether or not a stall occurs.
REQ-023 At each edge, entry 0 SHALL load {iss_valid&iss_we, iss_wa, iss_tnew} when stall=0 and flush=0; otherwise it SHALL load a bubble (v=0).
REQ-024 A stage i SHALL match a port when v=1, wa==rd_addr, and rd_addr≠0.
REQ-025 The priority SHALL be the youngest matching stage (lowest i); older matches SHALL be ignored.
REQ-026 Per port, when the youngest match has tnew==0, fwd_data SHALL be stg_data[i] and fwd_pend SHALL be 0.
REQ-027 Per port, when the youngest match has tnew>0, fwd_pend SHALL be 1 and fwd_data SHALL be rf_data.
REQ-028 Per port, with no match or with rd_addr==0, fwd_data SHALL be rf_data and fwd_pend SHALL be 0.
REQ-029 stall SHALL be the OR, over all ports, of (youngest match has tnew > rd_tuse); it is combinational, with zero-cycle latency.
REQ-030 When stall and flush are both asserted, the result SHALL be a bubble in entry 0; flush causes no additional behaviour.
REQ-031 stall_cnt SHALL increment on every edge where stall=1 and SHALL hold at 16'hFFFF.

Reset
REQ-032 When reset=1 at an edge, all entries SHALL be cleared (v=0, wa=0, tnew=0) and stall_cnt SHALL be set to 0.
REQ-033 Reset SHALL take priority over the issue, stall and flush inputs in the same cycle.
REQ-034 In the cycle after reset, the outputs SHALL be stall=0, fwd_pend=0 and fwd_data=rf_data.

Structure
REQ-035 The shared package cpu_pkg SHALL hold the table-entry typedef, the TNEW_ALU/TNEW_LOAD/TNEW_LINK constants and the default TW.
REQ-036 A sub-module bypass_lookup (one per port, instantiated by generate) SHALL perform the youngest-match search and the data select.
REQ-037 The table and stall_cnt SHALL be the only state in the block.

Verification
REQ-038 Scenario: issue lw $8 (tnew=2), then addu reading $8 with tuse=1 -> stall=1 for exactly 1 cycle, then fwd_pend=1 with the producer in M; next cycle fwd_data=stg_data[W] of $8.
REQ-039 Scenario: addu $9 (tnew=1); next cycle beq reading $9 with tuse=0 -> stall=1 for 1 cycle, then fwd_data=stg_data[M]=0x0000_1234 when the M slice is driven with 0x1234.
REQ-040 Scenario: $5 present in M (tnew=0) and W simultaneously, port0 reads $5 -> fwd_data=M data 0xAAAA_0001, not the W data.
REQ-041 Scenario: read $0 while an entry has wa=0, v=1 -> fwd_data=rf_data=0, stall=0.
REQ-042 Scenario: flush=1 with iss_valid=1 wa=$3 -> next cycle a read of $3 returns rf_data with no stall; jal (wa=31, tnew=0) -> next cycle $31 is forwarded from E.
REQ-043 Scenario: hold a stalling condition for 70000 cycles -> stall_cnt=16'hFFFF; assert reset mid-stall -> next cycle stall_cnt=0, stall=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: hazard-table entry, producer latency constants and
// the saturating Tnew decrement.
package cpu_pkg;

  localparam int unsigned TW_DEF = 2;
  localparam int unsigned REG_AW = 5;

  localparam logic [TW_DEF-1:0] TNEW_LINK = 2'd0;
  localparam logic [TW_DEF-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TW_DEF-1:0] TNEW_LOAD = 2'd2;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] wa;
    logic [TW_DEF-1:0] tnew;
  } entry_t;

  function automatic logic [TW_DEF-1:0] tnew_dec(input logic [TW_DEF-1:0] t);
    return (t == '0) ? '0 : t - TW_DEF'(1);
  endfunction

endpackage

// File: rtl/bypass_sched_if.sv
// Issue, operand-read and forwarding signals between the D stage and the bypass scheduler.
interface bypass_sched_if import cpu_pkg::*; #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NSTG = 3,
  parameter int unsigned NRD  = 2,
  parameter int unsigned TW   = TW_DEF
);

  logic                iss_valid;
  logic                iss_we;
  logic [AW-1:0]       iss_wa;
  logic [TW-1:0]       iss_tnew;
  logic                flush;
  logic [NSTG*DW-1:0]  stg_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*TW-1:0]   rd_tuse;
  logic [NRD*DW-1:0]   rf_data;
  logic [NRD*DW-1:0]   fwd_data;
  logic [NRD-1:0]      fwd_pend;
  logic                stall;
  logic [15:0]         stall_cnt;

  modport slave (
    input  iss_valid, iss_we, iss_wa, iss_tnew, flush, stg_data, rd_addr, rd_tuse, rf_data,
    output fwd_data, fwd_pend, stall, stall_cnt
  );

  modport master (
    output iss_valid, iss_we, iss_wa, iss_tnew, flush, stg_data, rd_addr, rd_tuse, rf_data,
    input  fwd_data, fwd_pend, stall, stall_cnt
  );

endinterface

// File: rtl/bypass_lookup.sv
// One read port: find the youngest in-flight producer of the operand and pick
// either its stage data or the register-file value.
module bypass_lookup #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NSTG = 3,
  parameter int unsigned TW   = 2
) (
  input  logic [AW-1:0]      rd_addr_i,
  input  logic [TW-1:0]      rd_tuse_i,
  input  logic [DW-1:0]      rf_data_i,
  input  logic [NSTG*DW-1:0] stg_data_i,
  input  logic [NSTG-1:0]    ent_v_i,
  input  logic [NSTG*AW-1:0] ent_wa_i,
  input  logic [NSTG*TW-1:0] ent_tnew_i,
  output logic [DW-1:0]      fwd_data_o,
  output logic               fwd_pend_o,
  output logic               stall_o
);

  logic          hit;
  logic [TW-1:0] hit_tnew;
  logic [DW-1:0] hit_data;

  always_comb begin
    hit      = 1'b0;
    hit_tnew = '0;
    hit_data = '0;
    // Scan oldest to youngest so the youngest match overwrites older ones.
    for (int i = NSTG - 1; i >= 0; i--) begin
      if (ent_v_i[i] && (ent_wa_i[i*AW +: AW] == rd_addr_i)) begin
        hit      = 1'b1;
        hit_tnew = ent_tnew_i[i*TW +: TW];
        hit_data = stg_data_i[i*DW +: DW];
      end
    end
    if (rd_addr_i == '0) begin
      hit = 1'b0;
    end

    fwd_data_o = rf_data_i;
    fwd_pend_o = 1'b0;
    stall_o    = 1'b0;
    if (hit) begin
      if (hit_tnew == '0) begin
        fwd_data_o = hit_data;
      end else begin
        fwd_pend_o = 1'b1;
      end
      stall_o = (hit_tnew > rd_tuse_i);
    end
  end

endmodule

// File: rtl/bypass_sched.sv
// Tnew/Tuse hazard scheduler: tracks destination registers in E/M/W, forwards
// ready results and stalls D when an operand cannot arrive in time.
module bypass_sched import cpu_pkg::*; #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = REG_AW,
  parameter int unsigned NSTG = 3,
  parameter int unsigned NRD  = 2,
  parameter int unsigned TW   = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  bypass_sched_if.slave bus
);

  entry_t [NSTG-1:0]  tbl_q, tbl_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;

  logic [NSTG-1:0]    ent_v;
  logic [NSTG*AW-1:0] ent_wa;
  logic [NSTG*TW-1:0] ent_tnew;
  logic [NRD-1:0]     port_stall;
  logic [NRD*DW-1:0]  fwd_data;
  logic [NRD-1:0]     fwd_pend;
  logic               stall;

  assign stall = |port_stall;

  always_comb begin
    tbl_d = '0;
    // A stalled or flushed issue slot becomes a bubble in E.
    if (!stall && !bus.flush) begin
      tbl_d[0].v    = bus.iss_valid & bus.iss_we;
      tbl_d[0].wa   = bus.iss_wa;
      tbl_d[0].tnew = bus.iss_tnew;
    end
    // E/M/W keep advancing during a stall; only D is frozen.
    for (int i = 1; i < NSTG; i++) begin
      tbl_d[i]      = tbl_q[i-1];
      tbl_d[i].tnew = tnew_dec(tbl_q[i-1].tnew);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      tbl_q       <= tbl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    ent_v    = '0;
    ent_wa   = '0;
    ent_tnew = '0;
    for (int i = 0; i < NSTG; i++) begin
      ent_v[i]              = tbl_q[i].v;
      ent_wa[i*AW +: AW]    = tbl_q[i].wa;
      ent_tnew[i*TW +: TW]  = tbl_q[i].tnew;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    bypass_lookup #(
      .DW   (DW),
      .AW   (AW),
      .NSTG (NSTG),
      .TW   (TW)
    ) u_lookup (
      .rd_addr_i  (bus.rd_addr[p*AW +: AW]),
      .rd_tuse_i  (bus.rd_tuse[p*TW +: TW]),
      .rf_data_i  (bus.rf_data[p*DW +: DW]),
      .stg_data_i (bus.stg_data),
      .ent_v_i    (ent_v),
      .ent_wa_i   (ent_wa),
      .ent_tnew_i (ent_tnew),
      .fwd_data_o (fwd_data[p*DW +: DW]),
      .fwd_pend_o (fwd_pend[p]),
      .stall_o    (port_stall[p])
    );
  end

  assign bus.fwd_data  = fwd_data;
  assign bus.fwd_pend  = fwd_pend;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_bypass_sched.sv
// Scenario bench for bypass_sched: expected {stall, fwd_pend, fwd_data} pushed per
// driven cycle and popped at the following negedge.
module tb_bypass_sched;
  import cpu_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NSTG = 3;
  localparam int unsigned NRD  = 2;
  localparam int unsigned TW   = 2;
  localparam int unsigned VW   = 1 + NRD + NRD * DW;

  localparam logic [DW-1:0] RF0   = 32'h0000_F0F0;
  localparam logic [DW-1:0] RF1   = 32'h0000_0F0F;
  localparam logic [DW-1:0] STG_E = 32'hEEEE_0000;
  localparam logic [DW-1:0] STG_M = 32'hAAAA_0001;
  localparam logic [DW-1:0] STG_W = 32'hBBBB_0002;

  typedef struct {
    string         name;
    logic [VW-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  bypass_sched_if #(.DW(DW), .AW(AW), .NSTG(NSTG), .NRD(NRD), .TW(TW)) bus ();

  bypass_sched #(
    .DW   (DW),
    .AW   (AW),
    .NSTG (NSTG),
    .NRD  (NRD),
    .TW   (TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  exp_t          e;
  logic [VW-1:0] obs;
  int            checks   = 0;
  int            failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    bus.iss_valid = 1'b0;
    bus.iss_we    = 1'b0;
    bus.iss_wa    = '0;
    bus.iss_tnew  = '0;
    bus.flush     = 1'b0;
    bus.stg_data  = {STG_W, STG_M, STG_E};
    bus.rd_addr   = '0;
    bus.rd_tuse   = '0;
    bus.rf_data   = {RF1, RF0};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input string n, input logic st, input logic [NRD-1:0] pend,
                      input logic [DW-1:0] d1, input logic [DW-1:0] d0);
    exp_t x;
    x.name = n;
    x.val  = {st, pend, d1, d0};
    sb.push_back(x);
  endtask

  task automatic issue(input logic [AW-1:0] wa, input logic [TW-1:0] tnew);
    bus.iss_valid = 1'b1;
    bus.iss_we    = 1'b1;
    bus.iss_wa    = wa;
    bus.iss_tnew  = tnew;
  endtask

  // Reset must win over a simultaneous issue of a load to $8.
  task automatic test_reset();
    set_defaults();
    issue(5'd8, TNEW_LOAD);
    do_reset();
    set_defaults();
    bus.rd_addr[AW-1:0] = 5'd8;
    push("reset_outputs", 1'b0, 2'b00, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    checks++;
    if (bus.stall_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL reset_stall_cnt: got %h want %h", bus.stall_cnt, 16'h0000);
    end
  endtask

  task automatic test_load_use();
    set_defaults();
    do_reset();
    issue(5'd8, TNEW_LOAD);
    bus.rd_addr[AW-1:0] = 5'd1;
    bus.rd_tuse[TW-1:0] = 2'd1;
    push("lu_issue", 1'b0, 2'b00, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    tick();
    // addu reads $8; flush alongside the stall must not change anything.
    issue(5'd10, TNEW_ALU);
    bus.flush           = 1'b1;
    bus.rd_addr[AW-1:0] = 5'd8;
    push("lu_stall", 1'b1, 2'b01, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    tick();
    bus.flush = 1'b0;
    push("lu_pend_m", 1'b0, 2'b01, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    tick();
    bus.iss_valid = 1'b0;
    bus.stg_data  = {32'h8888_0008, STG_M, STG_E};
    push("lu_fwd_w", 1'b0, 2'b00, RF1, 32'h8888_0008);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    checks++;
    if (bus.stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL lu_stall_cnt: got %h want %h", bus.stall_cnt, 16'd1);
    end
  endtask

  task automatic test_branch();
    set_defaults();
    do_reset();
    issue(5'd9, TNEW_ALU);
    tick();
    bus.iss_we          = 1'b0;
    bus.iss_wa          = '0;
    bus.rd_addr[AW-1:0] = 5'd9;
    bus.rd_tuse[TW-1:0] = 2'd0;
    push("br_stall", 1'b1, 2'b01, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    tick();
    bus.stg_data = {STG_W, 32'h0000_1234, STG_E};
    push("br_fwd_m", 1'b0, 2'b00, RF1, 32'h0000_1234);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
  endtask

  task automatic test_priority();
    set_defaults();
    do_reset();
    issue(5'd5, TNEW_ALU);
    tick();
    tick();
    bus.iss_valid = 1'b0;
    bus.rd_addr   = {5'd5, 5'd5};
    bus.rd_tuse   = {2'd1, 2'd1};
    push("pr_pend_e", 1'b0, 2'b11, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    tick();
    bus.rd_tuse = '0;
    push("pr_youngest_m", 1'b0, 2'b00, STG_M, STG_M);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
  endtask

  task automatic test_zero_reg();
    set_defaults();
    do_reset();
    issue(5'd0, TNEW_LOAD);
    tick();
    bus.iss_valid = 1'b0;
    bus.rf_data   = {RF1, 32'h0000_0000};
    push("zr_read0", 1'b0, 2'b00, RF1, 32'h0000_0000);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
  endtask

  task automatic test_flush_jal();
    set_defaults();
    do_reset();
    issue(5'd3, TNEW_ALU);
    bus.flush = 1'b1;
    tick();
    bus.flush           = 1'b0;
    issue(5'd31, TNEW_LINK);
    bus.rd_addr[AW-1:0] = 5'd3;
    push("fl_no_fwd", 1'b0, 2'b00, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    tick();
    bus.iss_valid       = 1'b0;
    bus.rd_addr[AW-1:0] = 5'd31;
    bus.stg_data        = {STG_W, STG_M, 32'hEEEE_0031};
    push("jal_fwd_e", 1'b0, 2'b00, RF1, 32'hEEEE_0031);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
  endtask

  // Constant issue of a tnew=3 producer read with tuse=0 repeats a 4-cycle
  // pattern: one issue cycle then three stall cycles (E, M, W).
  task automatic test_stall_sat();
    set_defaults();
    issue(5'd8, 2'd3);
    bus.rd_addr[AW-1:0] = 5'd8;
    do_reset();
    push("sat_first", 1'b0, 2'b00, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    repeat (4) @(posedge clk);
    #1;
    push("sat_period", 1'b0, 2'b00, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    checks++;
    if (bus.stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL sat_cnt3: got %h want %h", bus.stall_cnt, 16'd3);
    end
    // Cycle 4 -> 87385 (phase 1): 65538 stalls seen, counter pinned at FFFF.
    repeat (87381) @(posedge clk);
    #1;
    push("sat_stall", 1'b1, 2'b01, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    checks++;
    if (bus.stall_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_cnt_max: got %h want %h", bus.stall_cnt, 16'hFFFF);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push("sat_after_reset", 1'b0, 2'b00, RF1, RF0);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.stall, bus.fwd_pend, bus.fwd_data};
    checks++;
    if (obs !== e.val) begin
      failures++;
      $display("FAIL %s: got %h want %h", e.name, obs, e.val);
    end
    checks++;
    if (bus.stall_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL sat_cnt_reset: got %h want %h", bus.stall_cnt, 16'h0000);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_defaults();
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_zero_reg();
    test_flush_jal();
    test_stall_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
